// File: rtl/ct_ciu_l2c_rbeat_if.sv
// Bundle of the L2C write-back completion push and the CIU response beat channel.
interface ct_ciu_l2c_rbeat_if;
    logic         l2c_ciu_cmplt;
    logic [4:0]   l2c_ciu_resp;
    logic [3:0]   l2c_ciu_cp;
    logic [4:0]   l2c_ciu_sid;
    logic [511:0] l2c_ciu_data;
    logic         rbeat_vld;
    logic         rbeat_rdy;
    logic [127:0] rbeat_data;
    logic [4:0]   rbeat_sid;
    logic [4:0]   rbeat_resp;
    logic         rbeat_last;
    logic         rbeat_credit;
    logic         rbuf_empty;
    logic         rbuf_ovf_err;

    modport master (
        output l2c_ciu_cmplt, l2c_ciu_resp, l2c_ciu_cp, l2c_ciu_sid, l2c_ciu_data, rbeat_rdy,
        input  rbeat_vld, rbeat_data, rbeat_sid, rbeat_resp, rbeat_last, rbeat_credit,
               rbuf_empty, rbuf_ovf_err
    );

    modport slave (
        input  l2c_ciu_cmplt, l2c_ciu_resp, l2c_ciu_cp, l2c_ciu_sid, l2c_ciu_data, rbeat_rdy,
        output rbeat_vld, rbeat_data, rbeat_sid, rbeat_resp, rbeat_last, rbeat_credit,
               rbuf_empty, rbuf_ovf_err
    );
endinterface

// File: rtl/ct_ciu_l2c_rbeat.sv
// Line FIFO behind the L2C WB stage, serialising 512-bit completions into 128-bit beats.
// Optional CIU_RBEAT_CRIT_WORD_FIRST_EN: start each data entry at beat cp[1:0] and wrap.
module ct_ciu_l2c_rbeat #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    ct_ciu_l2c_rbeat_if.slave       rbif
);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [511:0]     r_data [DEPTH];
    logic [4:0]       r_resp [DEPTH];
    logic [4:0]       r_sid  [DEPTH];
    logic             r_dp   [DEPTH];
`ifdef CIU_RBEAT_CRIT_WORD_FIRST_EN
    logic [1:0]       r_start [DEPTH];
`endif

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_cnt;
    logic [1:0]       r_bcnt;
    logic             r_credit;
    logic             r_ovf;

    logic             w_vld;
    logic             w_full;
    logic             w_last;
    logic             w_xfer;
    logic             w_pop;
    logic             w_push;
    logic [1:0]       w_start;
    logic [1:0]       w_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_vld  = (r_cnt != '0);
    assign w_full = (r_cnt == FULL_CNT);
    assign w_last = w_vld && (!r_dp[r_rptr] || (r_bcnt == 2'd3));
    assign w_xfer = w_vld && rbif.rbeat_rdy;
    assign w_pop  = w_xfer && w_last;
    // A last-beat pop frees its slot in the same cycle, so a push into a full buffer is accepted then.
    assign w_push = rbif.l2c_ciu_cmplt && (!w_full || w_pop);

`ifdef CIU_RBEAT_CRIT_WORD_FIRST_EN
    assign w_start = r_start[r_rptr];
`else
    assign w_start = 2'd0;
`endif
    assign w_idx = w_start + r_bcnt;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_bcnt   <= 2'd0;
            r_credit <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_xfer) r_bcnt <= w_last ? 2'd0 : r_bcnt + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            r_credit <= w_pop;
            if (rbif.l2c_ciu_cmplt && !w_push) r_ovf <= 1'b1;
        end
    end

    // Entry payload needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge forever_cpuclk) begin
        if (w_push) begin
            r_data[r_wptr]  <= rbif.l2c_ciu_data;
            r_resp[r_wptr]  <= rbif.l2c_ciu_resp;
            r_sid[r_wptr]   <= rbif.l2c_ciu_sid;
            r_dp[r_wptr]    <= rbif.l2c_ciu_cp[3];
`ifdef CIU_RBEAT_CRIT_WORD_FIRST_EN
            r_start[r_wptr] <= rbif.l2c_ciu_cp[1:0];
`endif
        end
    end

    assign rbif.rbeat_vld    = w_vld;
    assign rbif.rbeat_last   = w_last;
    assign rbif.rbeat_data   = (w_vld && r_dp[r_rptr]) ? r_data[r_rptr][{w_idx, 7'd0} +: 128] : '0;
    assign rbif.rbeat_sid    = w_vld ? r_sid[r_rptr]  : '0;
    assign rbif.rbeat_resp   = w_vld ? r_resp[r_rptr] : '0;
    assign rbif.rbeat_credit = r_credit;
    assign rbif.rbuf_empty   = !w_vld;
    assign rbif.rbuf_ovf_err = r_ovf;
endmodule

// File: tb/tb_ct_ciu_l2c_rbeat.sv
// Randomised scoreboard bench: a line-level model expands accepted completions into expected beats.
module tb_ct_ciu_l2c_rbeat;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ct_ciu_l2c_rbeat_if bus ();

    ct_ciu_l2c_rbeat #(.DEPTH(DEPTH), .PTR_W(1)) u_dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .rbif           (bus)
    );

    typedef struct {
        logic [127:0] data;
        logic [4:0]   sid;
        logic [4:0]   resp;
        logic         last;
    } beat_t;

    beat_t q[$];
    int    m_cnt      = 0;
    bit    m_pop_last = 1'b0;
    bit    exp_credit = 1'b0;
    bit    exp_ovf    = 1'b0;
    bit    mon_en     = 1'b0;
    int    n_chk      = 0;
    int    n_fail     = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One accepted line becomes 1 or 4 expected beats in delivery order.
    task automatic expand(input logic [3:0] cp, input logic [4:0] sid, input logic [4:0] resp,
                          input logic [511:0] d);
        beat_t b;
        int    st;
`ifdef CIU_RBEAT_CRIT_WORD_FIRST_EN
        st = int'(cp[1:0]);
`else
        st = 0;
`endif
        b.sid  = sid;
        b.resp = resp;
        if (cp[3]) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx    = (st + k) % 4;
                b.data = d[idx*128 +: 128];
                b.last = (k == 3);
                q.push_back(b);
            end
        end else begin
            b.data = '0;
            b.last = 1'b1;
            q.push_back(b);
        end
    endtask

    // Model: occupancy in lines, acceptance, overflow and credit at each clock edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_cnt      = 0;
                m_pop_last = 1'b0;
                exp_credit = 1'b0;
                exp_ovf    = 1'b0;
            end else begin
                exp_credit = m_pop_last;
                if (bus.l2c_ciu_cmplt) begin
                    if (m_cnt < DEPTH || m_pop_last) begin
                        expand(bus.l2c_ciu_cp, bus.l2c_ciu_sid, bus.l2c_ciu_resp, bus.l2c_ciu_data);
                        m_cnt++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
                if (m_pop_last) m_cnt--;
                m_pop_last = 1'b0;
            end
        end
    end

    // Monitor: compares the presented beat against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("vld", bus.rbeat_vld, (m_cnt != 0));
                chk("empty", bus.rbuf_empty, (m_cnt == 0));
                chk("credit", bus.rbeat_credit, exp_credit);
                chk("ovf_err", bus.rbuf_ovf_err, exp_ovf);
                if (bus.rbeat_vld && q.size() > 0) begin
                    chk("beat_data", bus.rbeat_data, q[0].data);
                    chk("beat_sid", bus.rbeat_sid, q[0].sid);
                    chk("beat_resp", bus.rbeat_resp, q[0].resp);
                    chk("beat_last", bus.rbeat_last, q[0].last);
                    if (bus.rbeat_rdy && !rst) begin
                        m_pop_last = q[0].last;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input bit c, input logic [3:0] cp, input logic [4:0] sid,
                            input logic [4:0] resp);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        bus.l2c_ciu_cmplt = c;
        bus.l2c_ciu_cp    = cp;
        bus.l2c_ciu_sid   = sid;
        bus.l2c_ciu_resp  = resp;
        bus.l2c_ciu_data  = d;
    endtask

    task automatic idle(input int n);
        bus.l2c_ciu_cmplt = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        bit found;
        bus.rbeat_rdy = 1'b0;
        set_push(1'b0, 4'h0, 5'h0, 5'h0);
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_vld", bus.rbeat_vld, 1'b0);
        chk("rst_last", bus.rbeat_last, 1'b0);
        chk("rst_data", bus.rbeat_data, 128'h0);
        chk("rst_sid", bus.rbeat_sid, 5'h0);
        chk("rst_resp", bus.rbeat_resp, 5'h0);
        chk("rst_credit", bus.rbeat_credit, 1'b0);
        chk("rst_empty", bus.rbuf_empty, 1'b1);
        chk("rst_ovf", bus.rbuf_ovf_err, 1'b0);
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single data line and a response-only entry with ready held high.
        bus.rbeat_rdy = 1'b1;
        set_push(1'b1, 4'b1000, 5'h0A, 5'h01); step();
        idle(7);
        set_push(1'b1, 4'b0000, 5'h03, 5'h02); step();
        idle(4);
        set_push(1'b1, 4'b1010, 5'h11, 5'h04); step();
        idle(7);

        // Overflow: fill with ready low, one extra push, then drain.
        bus.rbeat_rdy = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            set_push(1'b1, 4'b1000 | 4'(i), 5'(i + 1), 5'(i + 8)); step();
        end
        idle(3);
        bus.rbeat_rdy = 1'b1;
        idle(4 * DEPTH + 4);

        // Reset during beat 2 with a second line queued behind.
        set_push(1'b1, 4'b1000, 5'h15, 5'h05); step();
        set_push(1'b1, 4'b1000, 5'h16, 5'h06); step();
        idle(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);

        // Full buffer of response-only entries, push coincident with the last-beat pop.
        bus.rbeat_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, 4'b0000, 5'(i + 20), 5'(i)); step();
        end
        idle(2);
        bus.rbeat_rdy = 1'b1;
        set_push(1'b1, 4'b1000, 5'h1E, 5'h1F); step();
        idle(6);

        // Full buffer of data lines, push on the cycle the head shows its last beat.
        bus.rbeat_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, 4'b1000, 5'(i + 24), 5'(i + 2)); step();
        end
        idle(2);
        bus.rbeat_rdy = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.rbeat_vld && bus.rbeat_last) found = 1'b1;
            else step();
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL last_beat_wait: got no last beat within 10 cycles, required one");
        end
        set_push(1'b1, 4'b1001, 5'h1C, 5'h0C); step();
        idle(12);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            bus.rbeat_rdy = ($urandom_range(3) != 0);
            set_push(($urandom_range(2) == 0), 4'($urandom), 5'($urandom), 5'($urandom));
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        bus.rbeat_rdy = 1'b1;
        idle(4 * DEPTH + 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
